// File: rtl/axis_pkg.sv
// Shared types for the AXI4-Stream packet path: FIFO state encoding and the stored beat layout.
`timescale 1ns/1ps
package axis_pkg;

    typedef enum logic {ACCEPT, DROP} pfifo_state_e;

    localparam int AXIS_DATA_W = 32;

    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } axis_beat_t;

endpackage

// File: rtl/axis_pkt_mem.sv
// Beat storage for the packet FIFO: one synchronous write port, one asynchronous read port, no reset.
`timescale 1ns/1ps
module axis_pkt_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W:0]   wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W:0]   rdata_o
);

    logic [DATA_W:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI4-Stream packet FIFO: packets become visible downstream only once their
// tlast beat is stored; packets longer than DEPTH beats are discarded whole and counted.
//   state  | meaning
//   ACCEPT | storing beats of the open packet, tready follows FIFO space
//   DROP   | swallowing the rest of an oversize packet until its tlast
`timescale 1ns/1ps
module axis_packet_fifo
    import axis_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 16,
    parameter int  CNT_W  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              axis_aclk,
    input  logic              axis_aresetn,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tvalid,
    output logic              s0_axis_tready,
    input  logic              s0_axis_tlast,
    output logic [DATA_W-1:0] m0_axis_tdata,
    output logic              m0_axis_tvalid,
    input  logic              m0_axis_tready,
    output logic              m0_axis_tlast,
    output logic [ADDR_W:0]   pkt_count,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    pfifo_state_e    state_q, state_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] wr_commit_q, wr_commit_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [ADDR_W:0] used, pend;
    logic            in_hs, out_hs, mem_we, commit;
    logic [DATA_W:0] rd_beat;

    assign used = wr_ptr_q - rd_ptr_q;
    assign pend = wr_ptr_q - wr_commit_q;

    // Ready is held low while reset is asserted so nothing is accepted into a clearing FIFO.
    assign s0_axis_tready = axis_aresetn && ((state_q == DROP) || (used != DEPTH_P));
    assign in_hs          = s0_axis_tvalid && s0_axis_tready;
    assign mem_we         = in_hs && (state_q == ACCEPT);

    assign m0_axis_tvalid = (rd_ptr_q != wr_commit_q);
    assign out_hs         = m0_axis_tvalid && m0_axis_tready;
    assign m0_axis_tlast  = rd_beat[DATA_W];
    assign m0_axis_tdata  = rd_beat[DATA_W-1:0];

    assign pkt_count  = pkt_cnt_q;
    assign drop_count = drop_cnt_q;

    axis_pkt_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (axis_aclk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i ({s0_axis_tlast, s0_axis_tdata}),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_beat)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        drop_cnt_d  = drop_cnt_q;
        commit      = 1'b0;
        unique case (state_q)
            ACCEPT: begin
                if (in_hs) begin
                    if (s0_axis_tlast) begin
                        wr_ptr_d    = wr_ptr_q + PTR_ONE;
                        wr_commit_d = wr_ptr_q + PTR_ONE;
                        commit      = 1'b1;
                    end else if (pend + PTR_ONE == DEPTH_P) begin
                        // Packet cannot fit even in an empty FIFO: roll back and discard the rest.
                        wr_ptr_d = wr_commit_q;
                        state_d  = DROP;
                        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end
            end
            DROP: begin
                if (in_hs && s0_axis_tlast) state_d = ACCEPT;
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_comb begin
        rd_ptr_d  = out_hs ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        case ({commit, out_hs && m0_axis_tlast})
            2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
            2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q     <= ACCEPT;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Self-checking bench for axis_packet_fifo: packet-level reference model (whole packets kept or dropped).
`timescale 1ns/1ps
module tb_axis_packet_fifo;
    import axis_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [4:0]  pkt_cnt;
    logic [15:0] drop_cnt;

    logic rdy_mode  = 1'b0;
    logic rdy_fixed = 1'b0;
    logic rdy_rnd   = 1'b0;
    assign m_tready = rdy_mode ? rdy_rnd : rdy_fixed;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int exp_drop = 0;
    axis_beat_t exp_q[$];
    axis_beat_t rx_q[$];
    int         rx_cyc[$];

    always #2.5 clk = ~clk;

    axis_packet_fifo #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .axis_aclk      (clk),
        .axis_aresetn   (rst_n),
        .s0_axis_tdata  (s_tdata),
        .s0_axis_tvalid (s_tvalid),
        .s0_axis_tready (s_tready),
        .s0_axis_tlast  (s_tlast),
        .m0_axis_tdata  (m_tdata),
        .m0_axis_tvalid (m_tvalid),
        .m0_axis_tready (m_tready),
        .m0_axis_tlast  (m_tlast),
        .pkt_count      (pkt_cnt),
        .drop_count     (drop_cnt)
    );

    always @(posedge clk) begin
        cyc++;
        #1;
        rdy_rnd = 1'($urandom_range(0, 1));
    end

    // Inputs only change 1 ns after a rising edge, so a negedge sample predicts the next edge's handshake.
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            rx_q.push_back(axis_beat_t'{last: m_tlast, data: m_tdata});
            rx_cyc.push_back(cyc);
        end
    end

    task automatic push_beat(input logic [31:0] d, input logic last, output int waits);
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        waits    = 0;
        @(negedge clk);
        while (!s_tready && waits < 500) begin
            waits++;
            @(negedge clk);
        end
        n_checks++;
        if (!s_tready) begin
            n_fails++;
            $display("FAIL push_timeout: beat %h not accepted, tready=%b required 1", d, s_tready);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [31:0] base, input bit rnd, output int max_wait);
        int          w;
        logic [31:0] d;
        max_wait = 0;
        for (int i = 0; i < len; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            d = rnd ? $urandom : base + 32'(i);
            if (len <= DEPTH) exp_q.push_back(axis_beat_t'{last: (i == len - 1), data: d});
            push_beat(d, i == len - 1, w);
            if (w > max_wait) max_wait = w;
        end
        if (len > DEPTH && exp_drop != 65535) exp_drop++;
    endtask

    task automatic wait_rx(input int n, input string tag);
        int t = 0;
        while (rx_q.size() < n && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (rx_q.size() != n) begin
            n_fails++;
            $display("FAIL %s rx_count: got %0d beats, required %0d", tag, rx_q.size(), n);
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        rx_q.delete();
        rx_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks += 4;
        if (s_tready !== 1'b0) begin n_fails++; $display("FAIL reset_tready: got %b required 0", s_tready); end
        if (m_tvalid !== 1'b0) begin n_fails++; $display("FAIL reset_tvalid: got %b required 0", m_tvalid); end
        if (pkt_cnt !== 5'd0)  begin n_fails++; $display("FAIL reset_pkt: got %0d required 0", pkt_cnt); end
        if (drop_cnt !== 16'd0) begin n_fails++; $display("FAIL reset_drop: got %0d required 0", drop_cnt); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (s_tready !== 1'b1) begin n_fails++; $display("FAIL release_tready: got %b required 1", s_tready); end
    endtask

    task automatic test_basic();
        int w;
        axis_beat_t got;
        clear_queues();
        rdy_fixed = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            exp_q.push_back(axis_beat_t'{last: (i == 10), data: 32'(i)});
            push_beat(32'(i), i == 10, w);
            n_checks += 2;
            if (m_tvalid !== (i == 10)) begin
                n_fails++;
                $display("FAIL basic_tvalid after beat %0d: got %b required %b", i, m_tvalid, i == 10);
            end
            if (pkt_cnt !== ((i == 10) ? 5'd1 : 5'd0)) begin
                n_fails++;
                $display("FAIL basic_pkt after beat %0d: got %0d", i, pkt_cnt);
            end
        end
        wait_rx(10, "basic");
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fails++;
                $display("FAIL basic beat %0d: got %h required %h", i, got, exp_q[i]);
            end
            if (i > 0 && i < rx_cyc.size()) begin
                n_checks++;
                if (rx_cyc[i] != rx_cyc[0] + i) begin
                    n_fails++;
                    $display("FAIL basic_stream beat %0d: cycle %0d required %0d", i, rx_cyc[i], rx_cyc[0] + i);
                end
            end
        end
        n_checks++;
        if (pkt_cnt !== 5'd0) begin n_fails++; $display("FAIL basic_pkt_end: got %0d required 0", pkt_cnt); end
    endtask

    task automatic test_exact_fit();
        int mw;
        axis_beat_t got;
        clear_queues();
        rdy_fixed = 1'b1;
        send_pkt(16, 32'h500, 1'b0, mw);
        wait_rx(16, "exact");
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fails++;
                $display("FAIL exact beat %0d: got %h required %h", i, got, exp_q[i]);
            end
        end
        n_checks++;
        if (drop_cnt !== 16'(exp_drop)) begin n_fails++; $display("FAIL exact_drop: got %0d required %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_oversize();
        int mw1, mw2;
        axis_beat_t got;
        clear_queues();
        rdy_fixed = 1'b1;
        send_pkt(20, 32'd1, 1'b0, mw1);
        send_pkt(3, 32'hA, 1'b0, mw2);
        n_checks++;
        if (mw1 != 0 || mw2 != 0) begin
            n_fails++;
            $display("FAIL oversize_tready: stalled %0d/%0d cycles, required 0", mw1, mw2);
        end
        wait_rx(3, "oversize");
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fails++;
                $display("FAIL oversize beat %0d: got %h required %h", i, got, exp_q[i]);
            end
        end
        n_checks++;
        if (drop_cnt !== 16'(exp_drop)) begin n_fails++; $display("FAIL oversize_drop: got %0d required %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_backpressure();
        int mw, w;
        axis_beat_t got;
        clear_queues();
        rdy_fixed = 1'b0;
        send_pkt(8, 32'h200, 1'b0, mw);
        send_pkt(8, 32'h300, 1'b0, mw);
        n_checks++;
        if (pkt_cnt !== 5'd2) begin n_fails++; $display("FAIL bp_pkt: got %0d required 2", pkt_cnt); end
        s_tdata  = 32'h400;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (s_tready !== 1'b0) begin n_fails++; $display("FAIL bp_full_tready: got %b required 0", s_tready); end
        end
        @(posedge clk); #1;
        rdy_fixed = 1'b1;
        exp_q.push_back(axis_beat_t'{last: 1'b1, data: 32'h400});
        push_beat(32'h400, 1'b1, w);
        wait_rx(17, "backpressure");
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fails++;
                $display("FAIL bp beat %0d: got %h required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w, mw;
        axis_beat_t got;
        clear_queues();
        rdy_fixed = 1'b1;
        for (int i = 0; i < 5; i++) push_beat(32'h600 + 32'(i), 1'b0, w);
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (s_tready !== 1'b0) begin n_fails++; $display("FAIL midrst_tready: got %b required 0", s_tready); end
        if (m_tvalid !== 1'b0) begin n_fails++; $display("FAIL midrst_tvalid: got %b required 0", m_tvalid); end
        if (pkt_cnt !== 5'd0)  begin n_fails++; $display("FAIL midrst_pkt: got %0d required 0", pkt_cnt); end
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        exp_drop = 0;
        send_pkt(4, 32'h700, 1'b0, mw);
        wait_rx(4, "reset_mid");
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fails++;
                $display("FAIL midrst beat %0d: got %h required %h", i, got, exp_q[i]);
            end
        end
        n_checks++;
        if (drop_cnt !== 16'(exp_drop)) begin n_fails++; $display("FAIL midrst_drop: got %0d required %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_random();
        int mw;
        axis_beat_t got;
        clear_queues();
        rdy_mode = 1'b1;
        for (int p = 0; p < 25; p++) send_pkt($urandom_range(1, 20), 32'd0, 1'b1, mw);
        wait_rx(exp_q.size(), "random");
        rdy_mode = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fails++;
                $display("FAIL random beat %0d: got %h required %h", i, got, exp_q[i]);
            end
        end
        n_checks += 2;
        if (drop_cnt !== 16'(exp_drop)) begin n_fails++; $display("FAIL random_drop: got %0d required %0d", drop_cnt, exp_drop); end
        if (pkt_cnt !== 5'd0) begin n_fails++; $display("FAIL random_pkt: got %0d required 0", pkt_cnt); end
    endtask

    task automatic test_sat_concurrency();
        int mw;
        axis_beat_t got;
        clear_queues();
        rdy_fixed = 1'b1;
        force dut.drop_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.drop_cnt_q;
        exp_drop = 65535;
        @(posedge clk); #1;
        n_checks++;
        if (drop_cnt !== 16'(exp_drop)) begin n_fails++; $display("FAIL sat_preset: got %h required %h", drop_cnt, 16'(exp_drop)); end
        send_pkt(18, 32'h800, 1'b0, mw);
        send_pkt(2, 32'h900, 1'b0, mw);
        wait_rx(2, "saturate");
        n_checks++;
        if (drop_cnt !== 16'(exp_drop)) begin n_fails++; $display("FAIL sat_drop: got %h required %h", drop_cnt, 16'(exp_drop)); end

        rdy_fixed = 1'b0;
        send_pkt(1, 32'hA00, 1'b0, mw);
        n_checks++;
        if (pkt_cnt !== 5'd1) begin n_fails++; $display("FAIL conc_pre_pkt: got %0d required 1", pkt_cnt); end
        exp_q.push_back(axis_beat_t'{last: 1'b1, data: 32'hB00});
        s_tdata   = 32'hB00;
        s_tlast   = 1'b1;
        s_tvalid  = 1'b1;
        rdy_fixed = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        n_checks++;
        if (pkt_cnt !== 5'd1) begin n_fails++; $display("FAIL conc_pkt: got %0d required 1", pkt_cnt); end
        wait_rx(4, "concurrency");
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fails++;
                $display("FAIL conc beat %0d: got %h required %h", i, got, exp_q[i]);
            end
        end
        n_checks++;
        if (pkt_cnt !== 5'd0) begin n_fails++; $display("FAIL conc_pkt_end: got %0d required 0", pkt_cnt); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_exact_fit();
        test_oversize();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_sat_concurrency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fails);
        $fatal(1, "watchdog expired");
    end

endmodule
